// File: rtl/shift_rows_pipe_if.sv
// rtl/shift_rows_pipe_if.sv - handshake and data bundle for the ShiftRows pipeline
interface shift_rows_pipe_if #(
    parameter int NB = 4
) ();
    localparam int DATA_WIDTH = 32 * NB;

    logic                  shiftRows_valid_in;
    logic                  shiftRows_ready_out;
    logic                  shiftRows_inv_in;
    logic [DATA_WIDTH-1:0] shiftRows_data_in;
    logic                  shiftRows_valid_out;
    logic                  shiftRows_ready_in;
    logic [DATA_WIDTH-1:0] shiftRows_data_out;
    logic [31:0]           shiftRows_blk_count;

    modport master (
        output shiftRows_valid_in, shiftRows_inv_in, shiftRows_data_in, shiftRows_ready_in,
        input  shiftRows_ready_out, shiftRows_valid_out, shiftRows_data_out, shiftRows_blk_count
    );

    modport slave (
        input  shiftRows_valid_in, shiftRows_inv_in, shiftRows_data_in, shiftRows_ready_in,
        output shiftRows_ready_out, shiftRows_valid_out, shiftRows_data_out, shiftRows_blk_count
    );
endinterface

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - pipelined Rijndael ShiftRows/InvShiftRows with valid/ready flow control
module shift_rows_pipe #(
    parameter int NB          = 4,
    parameter int PIPE_STAGES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_rows_pipe_if.slave   bus
);
    localparam int DATA_WIDTH = 32 * NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: PIPE_STAGES must be in 1..4");
    end

    function automatic int row_shift(input int r);
        case (r)
            0:       return 0;
            1:       return 1;
            2:       return (NB == 8) ? 3 : 2;
            default: return (NB == 8) ? 4 : 3;
        endcase
    endfunction

    // Byte 0 is the MSB byte; byte k sits at row k%4, column k/4.
    function automatic logic [DATA_WIDTH-1:0] permute(input logic [DATA_WIDTH-1:0] x,
                                                      input logic inv);
        logic [DATA_WIDTH-1:0] y;
        int r;
        int c;
        int s;
        int src;
        y = '0;
        for (int k = 0; k < 4 * NB; k++) begin
            r   = k % 4;
            c   = k / 4;
            s   = row_shift(r);
            src = inv ? ((c - s + NB) % NB) : ((c + s) % NB);
            y[DATA_WIDTH-1-8*k -: 8] = x[DATA_WIDTH-1-8*(4*src+r) -: 8];
        end
        return y;
    endfunction

    logic [PIPE_STAGES-1:0] v;
    logic [DATA_WIDTH-1:0]  d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] adv;
    logic [31:0]            blk_count_q;
    logic                   room;
    logic                   in_hs;
    logic                   out_hs;

    // A stage moves when output is ready or any later stage has a hole;
    // written without a chained dependency so the ready path stays flat.
    always_comb begin
        adv  = '0;
        room = 1'b0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            room = bus.shiftRows_ready_in;
            for (int j = i + 1; j < PIPE_STAGES; j++) begin
                room = room | ~v[j];
            end
            adv[i] = v[i] & room;
        end
    end

    assign bus.shiftRows_ready_out = rst_n & (~v[0] | adv[0]);
    assign in_hs                   = bus.shiftRows_valid_in & bus.shiftRows_ready_out;
    assign out_hs                  = v[PIPE_STAGES-1] & bus.shiftRows_ready_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v           <= '0;
            blk_count_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                d[i] <= '0;
            end
        end else begin
            if (in_hs) begin
                v[0] <= 1'b1;
                d[0] <= permute(bus.shiftRows_data_in, bus.shiftRows_inv_in);
            end else if (adv[0]) begin
                v[0] <= 1'b0;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                if (adv[i-1]) begin
                    v[i] <= 1'b1;
                    d[i] <= d[i-1];
                end else if (adv[i]) begin
                    v[i] <= 1'b0;
                end
            end
            if (out_hs) begin
                blk_count_q <= blk_count_q + 32'd1;
            end
        end
    end

    assign bus.shiftRows_valid_out = v[PIPE_STAGES-1];
    assign bus.shiftRows_data_out  = d[PIPE_STAGES-1];
    assign bus.shiftRows_blk_count = blk_count_q;
endmodule
